// File: rtl/mult_pipe_ctrl.sv
// mult_pipe_ctrl
//   Sequencer for the multi-cycle integer multiply pipeline. Tracks the valid
//   bit and destination register of every in-flight multiply, drives the
//   per-stage latch enables, flags RAW/WAW hazards back to decode and
//   arbitrates the shared integer writeback port (mult has fixed priority
//   because the mult pipe has no stall path).
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   kill_i                    flush: drops every in-flight op and any same-cycle issue
//   issue_valid_i/_rd_i       multiply issue from decode
//   issue_ready_o             issue accepted this cycle
//   dec_valid_i/_rs1/_rs2/_rd instruction in decode to be hazard-checked
//   hazard_o                  decode must stall
//   stage_valid_o             per-stage live bit (latch enable)
//   inflight_cnt_o            popcount of stage_valid_o
//   mult_wb_valid_o/_rd_o     mult writeback this cycle
//   alu_wb_valid_i            ALU requests writeback port
//   alu_wb_ready_o            ALU may write this cycle
//   wb_sel_o                  writeback mux select (1 = mult, 0 = ALU)

module mult_pipe_ctrl #(
    parameter int unsigned STAGES = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              kill_i,
    input  logic              issue_valid_i,
    input  logic [4:0]        issue_rd_i,
    output logic              issue_ready_o,
    input  logic              dec_valid_i,
    input  logic [4:0]        dec_rs1_i,
    input  logic [4:0]        dec_rs2_i,
    input  logic [4:0]        dec_rd_i,
    output logic              hazard_o,
    output logic [STAGES-1:0] stage_valid_o,
    output logic [3:0]        inflight_cnt_o,
    output logic              mult_wb_valid_o,
    output logic [4:0]        mult_wb_rd_o,
    input  logic              alu_wb_valid_i,
    output logic              alu_wb_ready_o,
    output logic              wb_sel_o
);

    logic [STAGES-1:0] v_q, v_d;
    logic [4:0]        rd_q [STAGES];
    logic [4:0]        rd_d [STAGES];
    logic              issue_accept;
    logic              hit;
    logic [3:0]        cnt;

    // True when a non-zero live rd matches any operand of the decode instruction.
    function automatic logic rd_match(input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2,
                                      input logic [4:0] drd);
        return (rd != 5'd0) && ((rd == rs1) || (rd == rs2) || (rd == drd));
    endfunction

    assign issue_ready_o = !rst_i && !kill_i;
    assign issue_accept  = issue_valid_i && issue_ready_o;

    // Shift register: no stall path, so every stage advances every cycle.
    always_comb begin
        v_d = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            rd_d[k] = '0;
        end
        if (!kill_i) begin
            v_d[0]  = issue_accept;
            rd_d[0] = issue_accept ? issue_rd_i : 5'd0;
            for (int unsigned k = 1; k < STAGES; k++) begin
                v_d[k]  = v_q[k-1];
                rd_d[k] = rd_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

    assign stage_valid_o = v_q;

    // Writeback: the last stage is gated by kill in the same cycle.
    assign mult_wb_valid_o = v_q[STAGES-1] && !kill_i;
    assign mult_wb_rd_o    = mult_wb_valid_o ? rd_q[STAGES-1] : 5'd0;
    assign wb_sel_o        = mult_wb_valid_o;
    assign alu_wb_ready_o  = !rst_i && !mult_wb_valid_o;

    // Hazard: every live stage (including the retiring one, no bypass) plus
    // the op being accepted into stage 0 this cycle.
    always_comb begin
        hit = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (v_q[k] && rd_match(rd_q[k], dec_rs1_i, dec_rs2_i, dec_rd_i)) begin
                hit = 1'b1;
            end
        end
        if (issue_accept && rd_match(issue_rd_i, dec_rs1_i, dec_rs2_i, dec_rd_i)) begin
            hit = 1'b1;
        end
    end

    assign hazard_o = dec_valid_i && hit;

    always_comb begin
        cnt = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            cnt = cnt + {3'd0, v_q[k]};
        end
    end

    assign inflight_cnt_o = cnt;

endmodule
